// File: rtl/cache_plru_pkg.sv
// Shared types and the tree-PLRU update rule for the 8-way victim selector.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: plru_t (7 tree bits, 1 = right side MRU), way_t, state_t, plru_update().
package cache_plru_pkg;

    typedef logic [6:0] plru_t;
    typedef logic [2:0] way_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RSP
    } state_t;

    // Point the three nodes on the path to 'way' toward it; other nodes keep their value.
    function automatic plru_t plru_update(plru_t bits, way_t way);
        plru_t nb;
        nb    = bits;
        nb[0] = way[2];
        if (!way[2]) begin
            nb[1] = way[1];
            if (!way[1]) nb[3] = way[0];
            else         nb[4] = way[0];
        end else begin
            nb[2] = way[1];
            if (!way[1]) nb[5] = way[0];
            else         nb[6] = way[0];
        end
        return nb;
    endfunction

endpackage

// File: rtl/cache_plru_decode.sv
// Victim way from tree-PLRU bits, with lowest invalid way taking priority.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: plru (7 tree bits), vmask (per-way valid bits), way (chosen victim).
module cache_plru_decode
    import cache_plru_pkg::*;
(
    input  logic [6:0] plru,
    input  logic [7:0] vmask,
    output logic [2:0] way
);

    way_t walk_way;

    // Walk from the root, always stepping to the LRU side (opposite of the MRU bit).
    always_comb begin
        walk_way    = '0;
        walk_way[2] = ~plru[0];
        if (!walk_way[2]) begin
            walk_way[1] = ~plru[1];
            walk_way[0] = walk_way[1] ? ~plru[4] : ~plru[3];
        end else begin
            walk_way[1] = ~plru[2];
            walk_way[0] = walk_way[1] ? ~plru[6] : ~plru[5];
        end
    end

    // Descending scan so the lowest-index invalid way is the last (winning) assignment.
    always_comb begin
        way = walk_way;
        if (!(&vmask)) begin
            for (int i = 7; i >= 0; i--) begin
                if (!vmask[i]) way = 3'(i);
            end
        end
    end

endmodule

// File: rtl/cache_plru_victim.sv
// Per-set 8-way tree-PLRU store with victim request/response and MRU update port.
// Latency: one cycle from request handshake to rsp_valid; response registers hold until consumed.
// Backpressure: req_ready low during INIT and while a response waits on rsp_ready.
// Ports: req_* (set, vmask), rsp_* (way, plru), upd_* (set, way made MRU); clk, async rst_n.
// Option: PLRU_VICTIM_AUTOUPD_EN makes each response handshake also mark rsp_way MRU in its set.
module cache_plru_victim
    import cache_plru_pkg::*;
#(
    parameter int SETS     = 64,
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(SETS)-1:0] req_set,
    input  logic [WAYS-1:0]         req_vmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WAYS_REP-1:0]     rsp_way,
    output logic [6:0]              rsp_plru,
    input  logic                    upd_valid,
    input  logic [$clog2(SETS)-1:0] upd_set,
    input  logic [WAYS_REP-1:0]     upd_way
);

    localparam int SET_W = $clog2(SETS);

    state_t           state_q, state_d;
    logic [SET_W-1:0] init_ptr_q;
    plru_t            mem [SETS];

    logic  req_fire;
    logic  upd_en;
    plru_t upd_next;
    plru_t req_bits;
    way_t  dec_way;

`ifdef PLRU_VICTIM_AUTOUPD_EN
    logic [SET_W-1:0] rsp_set_q;
    logic             auto_en;
    plru_t            auto_next;
`endif

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            INIT: begin
                if (init_ptr_q == SET_W'(SETS - 1)) state_d = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready && !req_valid) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    assign req_fire = req_valid & req_ready;
    assign upd_en   = upd_valid & (state_q != INIT);
    assign upd_next = plru_update(mem[upd_set], upd_way);

`ifdef PLRU_VICTIM_AUTOUPD_EN
    // Victim touch is applied on top of a same-cycle explicit update to the same set.
    assign auto_en   = rsp_valid & rsp_ready;
    assign auto_next = plru_update((upd_en && (upd_set == rsp_set_q)) ? upd_next : mem[rsp_set_q],
                                   rsp_way);
`endif

    // Captured bits reflect every write landing this cycle, in the same order the store applies them.
    always_comb begin
        req_bits = mem[req_set];
        if (upd_en && (upd_set == req_set)) req_bits = plru_update(req_bits, upd_way);
`ifdef PLRU_VICTIM_AUTOUPD_EN
        if (auto_en && (rsp_set_q == req_set)) req_bits = plru_update(req_bits, rsp_way);
`endif
    end

    cache_plru_decode u_decode (
        .plru  (req_bits),
        .vmask (req_vmask),
        .way   (dec_way)
    );

    // ---------------- PLRU store (cleared by INIT, not by reset) ----------------
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[init_ptr_q] <= '0;
        end else begin
            if (upd_en) mem[upd_set] <= upd_next;
`ifdef PLRU_VICTIM_AUTOUPD_EN
            // Same-set case: auto_next already folds in upd_next, so this write wins.
            if (auto_en) mem[rsp_set_q] <= auto_next;
`endif
        end
    end

    // ---------------- state and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            rsp_way    <= '0;
            rsp_plru   <= '0;
`ifdef PLRU_VICTIM_AUTOUPD_EN
            rsp_set_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_ptr_q <= init_ptr_q + SET_W'(1);
            if (req_fire) begin
                rsp_way   <= dec_way;
                rsp_plru  <= req_bits;
`ifdef PLRU_VICTIM_AUTOUPD_EN
                rsp_set_q <= req_set;
`endif
            end
        end
    end

endmodule
